// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares BRAM port B between instruction fetch (m0) and
// data load/store (m1) with round-robin arbitration and fixed-latency
// responses. Also sequences BRAM bring-up (bram_rst pulse, wait for busy to
// drop) before any request is granted.
// Optional build macro ARB_ADDR_CHECK_EN: misaligned or out-of-range requests
// are accepted but not issued to BRAM, and answer with rsp_err=1, rdata=0.

module bram_port_arbiter #(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter int          READ_LAT   = 1,
    parameter int          RST_CYCLES = 10,
    parameter logic [31:0] MEM_BYTES  = 32'h0004_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic                  m0_rsp_valid,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_rsp_err,
    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_rsp_valid,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  m1_rsp_err,
    output logic                  bram_en,
    output logic [DATA_W/8-1:0]   bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [DATA_W-1:0]     bram_din,
    input  logic [DATA_W-1:0]     bram_dout,
    output logic                  bram_rst,
    input  logic                  bram_rst_busy,
    output logic                  init_done
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(RST_CYCLES + 1);

`ifdef ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        INIT_RST  = 2'd0,
        INIT_WAIT = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               last_grant;

    logic               grant0, grant1, accept;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [STRB_W-1:0]  sel_wstrb;
    logic               sel_err;

    // Response tracking: p0 = issue cycle, p1/p2 = BRAM read latency stages
    logic               vld_p0, vld_p1, vld_p2;
    logic               id_p0, id_p1, id_p2;
    logic               wr_p0, wr_p1, wr_p2;
    logic               err_p0, err_p1, err_p2;
    logic               vld_o, id_o, wr_o, err_o;
    logic [DATA_W-1:0]  rd_o;

    // Word-aligned and inside the populated BRAM range
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a >= ADDR_W'(MEM_BYTES));
    endfunction

    // Bring-up state register and hold counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT_RST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Bring-up sequencing: hold bram_rst, wait for busy to clear, then run
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bram_rst  = 1'b0;
        init_done = 1'b0;
        case (state)
            INIT_RST: begin
                bram_rst = 1'b1;
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_nxt = INIT_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            INIT_WAIT: begin
                if (!bram_rst_busy) state_nxt = RUN;
            end
            RUN: begin
                init_done = 1'b1;
            end
            default: begin
                state_nxt = INIT_RST;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Round-robin grant: on a tie the requester not served last time wins
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == RUN && !bram_rst_busy) begin
            if (m0_req_valid && (!m1_req_valid || last_grant))
                grant0 = 1'b1;
            else if (m1_req_valid)
                grant1 = 1'b1;
        end
    end

    assign m0_req_ready = grant0;
    assign m1_req_ready = grant1;
    assign accept       = grant0 | grant1;
    assign sel_addr     = grant1 ? m1_addr  : m0_addr;
    assign sel_wdata    = grant1 ? m1_wdata : m0_wdata;
    assign sel_wstrb    = grant1 ? m1_wstrb : m0_wstrb;
    assign sel_err      = ADDR_CHECK && addr_bad(sel_addr);

    // Issue stage: register the granted request onto the BRAM port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bram_en    <= 1'b0;
            bram_we    <= '0;
            bram_addr  <= '0;
            bram_din   <= '0;
            last_grant <= 1'b1;
        end else begin
            bram_en <= accept && !sel_err;
            bram_we <= (accept && !sel_err) ? sel_wstrb : '0;
            if (accept) begin
                bram_addr  <= sel_addr;
                bram_din   <= sel_wdata;
                last_grant <= grant1;
            end
        end
    end

    // Response valid shift: cleared by reset so in-flight accesses are dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Response tag shift: requester id, write flag and error travel with valid
    always_ff @(posedge clk) begin
        id_p0  <= grant1;
        wr_p0  <= (sel_wstrb != '0);
        err_p0 <= sel_err;
        // p0 -> p1
        id_p1  <= id_p0;
        wr_p1  <= wr_p0;
        err_p1 <= err_p0;
        // p1 -> p2
        id_p2  <= id_p1;
        wr_p2  <= wr_p1;
        err_p2 <= err_p1;
    end

    assign vld_o = (READ_LAT == 2) ? vld_p2 : vld_p1;
    assign id_o  = (READ_LAT == 2) ? id_p2  : id_p1;
    assign wr_o  = (READ_LAT == 2) ? wr_p2  : wr_p1;
    assign err_o = (READ_LAT == 2) ? err_p2 : err_p1;

    // Steer the response to its requester; writes and errors return zero data
    always_comb begin
        rd_o         = (vld_o && !wr_o && !err_o) ? bram_dout : '0;
        m0_rsp_valid = vld_o && !id_o;
        m1_rsp_valid = vld_o &&  id_o;
        m0_rsp_err   = vld_o && !id_o && err_o;
        m1_rsp_err   = vld_o &&  id_o && err_o;
        m0_rdata     = id_o ? '0 : rd_o;
        m1_rdata     = id_o ? rd_o : '0;
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: drives both requesters and BRAM busy, models the BRAM
// port behaviourally, and scores every output against a reference model kept
// as plain arrays and queues.

module tb_bram_port_arbiter;

    localparam int          ADDR_W     = 32;
    localparam int          DATA_W     = 32;
    localparam int          READ_LAT   = 1;
    localparam int          RST_CYCLES = 10;
    localparam logic [31:0] MEM_BYTES  = 32'h0004_0000;

`ifdef ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    logic        tb_clk = 1'b0;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_req_valid, m1_req_ready, m1_rsp_valid, m1_rsp_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        bram_en, bram_rst, bram_rst_busy, init_done;
    logic [3:0]  bram_we;
    logic [31:0] bram_addr, bram_din, bram_dout;

    always #5 tb_clk = ~tb_clk;

    bram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT),
        .RST_CYCLES(RST_CYCLES), .MEM_BYTES(MEM_BYTES)
    ) dut (
        .clk(tb_clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rsp_valid(m0_rsp_valid),
        .m0_rdata(m0_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rsp_valid(m1_rsp_valid),
        .m1_rdata(m1_rdata), .m1_rsp_err(m1_rsp_err),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout), .bram_rst(bram_rst), .bram_rst_busy(bram_rst_busy),
        .init_done(init_done)
    );

    // Behavioural BRAM port B: byte-merging writes, read-first data after READ_LAT
    logic [31:0] bmem [0:255];
    logic [31:0] dout_s1, dout_s2;
    logic        mem_init = 1'b0;

    always @(posedge tb_clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) bmem[i] <= '0;
            mem_init <= 1'b1;
        end else if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bmem[bram_addr[9:2]][8*b +: 8] <= bram_din[8*b +: 8];
            dout_s1 <= bmem[bram_addr[9:2]];
        end
        dout_s2 <= dout_s1;
    end
    assign bram_dout = (READ_LAT == 2) ? dout_s2 : dout_s1;

    // Scoreboard state
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          edge_no;
    } exp_t;

    exp_t        q0[$], q1[$];
    logic [31:0] ref_mem [0:255];
    int          nchk = 0, npass = 0;
    int          k = 0;
    int          m_n;
    bit          m_run, m_last;
    bit          m_en;
    logic [3:0]  m_we;
    logic [31:0] m_addr, m_din;
    bit          exp_r0, exp_r1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s cycle %0d: got %h, want %h", name, k, act, exp);
    endtask

    task automatic model_reset();
        m_n = 0; m_run = 1'b0; m_last = 1'b1;
        m_en = 1'b0; m_we = '0; m_addr = '0; m_din = '0;
        q0.delete(); q1.delete();
    endtask

    // Apply the accepted request to the reference memory and queue its answer
    task automatic model_accept(input bit x, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s);
        exp_t e;
        bit   bad;
        bad       = ADDR_CHECK && ((a[1:0] != 2'b00) || (a >= MEM_BYTES));
        e.err     = bad;
        e.edge_no = k + 1 + READ_LAT;
        e.rdata   = '0;
        if (!bad) begin
            if (s != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
            end else begin
                e.rdata = ref_mem[a[9:2]];
            end
        end
        if (x) q1.push_back(e); else q0.push_back(e);
        m_en   = !bad;
        m_we   = bad ? 4'h0 : s;
        m_addr = a;
        m_din  = d;
        m_last = x;
    endtask

    task automatic check_rsp(input bit x, input logic v, input logic [31:0] rd, input logic er);
        exp_t e;
        bit   due;
        due = 1'b0;
        if (!x && q0.size() > 0) begin e = q0[0]; due = (e.edge_no == k); end
        if ( x && q1.size() > 0) begin e = q1[0]; due = (e.edge_no == k); end
        if (due) begin
            if (x) e = q1.pop_front(); else e = q0.pop_front();
        end
        if (v && !due) begin
            nchk++;
            $display("FAIL rsp_unexpected m%0d cycle %0d: got rsp_valid=1, want 0", x, k);
        end else if (!v && due) begin
            nchk++;
            $display("FAIL rsp_missing m%0d cycle %0d: got rsp_valid=0, want 1", x, k);
        end else if (v && due) begin
            chk(x ? "m1_rdata" : "m0_rdata", rd, e.rdata);
            chk(x ? "m1_rsp_err" : "m0_rsp_err", 32'(er), 32'(e.err));
        end
    endtask

    // Monitor: compare outputs each negedge, then advance the model past the next edge
    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        model_reset();
        forever begin
            @(negedge tb_clk);
            k++;
            chk("bram_rst",  32'(bram_rst),  32'(m_n < RST_CYCLES));
            chk("init_done", 32'(init_done), 32'(m_run));
            chk("bram_en",   32'(bram_en),   32'(m_en));
            chk("bram_we",   32'(bram_we),   32'(m_we));
            if (m_en) begin
                chk("bram_addr", bram_addr, m_addr);
                chk("bram_din",  bram_din,  m_din);
            end
            exp_r0 = m_run && !bram_rst_busy && m0_req_valid && (!m1_req_valid || m_last);
            exp_r1 = m_run && !bram_rst_busy && m1_req_valid && (!m0_req_valid || !m_last);
            chk("m0_req_ready", 32'(m0_req_ready), 32'(exp_r0));
            chk("m1_req_ready", 32'(m1_req_ready), 32'(exp_r1));
            check_rsp(1'b0, m0_rsp_valid, m0_rdata, m0_rsp_err);
            check_rsp(1'b1, m1_rsp_valid, m1_rdata, m1_rsp_err);
            if (!rst_n) begin
                model_reset();
            end else begin
                m_en = 1'b0;
                m_we = '0;
                if (exp_r0)      model_accept(1'b0, m0_addr, m0_wdata, m0_wstrb);
                else if (exp_r1) model_accept(1'b1, m1_addr, m1_wdata, m1_wstrb);
                if (m_n < RST_CYCLES)               m_n++;
                else if (!m_run && !bram_rst_busy)  m_run = 1'b1;
            end
        end
    end

    // Stimulus helpers: called at posedge+1, return at posedge+1 after acceptance
    task automatic wait_acc(input bit x);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge tb_clk);
            got = x ? (m1_req_valid && m1_req_ready) : (m0_req_valid && m0_req_ready);
        end
        @(posedge tb_clk); #1;
        if (x) m1_req_valid = 1'b0; else m0_req_valid = 1'b0;
        if (!got) begin
            nchk++;
            $display("FAIL accept_timeout m%0d: got no ready in 64 cycles, want acceptance", x);
        end
    endtask

    task automatic drive(input bit x, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        if (x) begin m1_req_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_wstrb = s; end
        else   begin m0_req_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_wstrb = s; end
        wait_acc(x);
    endtask

    task automatic rand_req(output logic [31:0] a, output logic [31:0] d, output logic [3:0] s);
        a = 32'($urandom_range(0, 15)) << 2;
        if (ADDR_CHECK && $urandom_range(0, 7) == 0)
            a = ($urandom_range(0, 1) == 0) ? (a | 32'h1) : (MEM_BYTES + a);
        d = $urandom;
        s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    endtask

    // Stimulus sequence
    initial begin
        bit a0, a1;
        rst_n = 1'b0; bram_rst_busy = 1'b1;
        m0_req_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_req_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        repeat (3) @(posedge tb_clk);
        #1;
        // m0 holds a read through the whole init sequence; busy stays up 3 cycles past bram_rst
        m0_req_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0;
        rst_n = 1'b1;
        repeat (RST_CYCLES + 3) @(posedge tb_clk);
        #1 bram_rst_busy = 1'b0;
        wait_acc(1'b0);

        // Full write, read back, partial write, read back
        drive(1'b1, 32'h0, 32'hDEADBEEF, 4'hF);
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 32'h0, 32'h0000_5678, 4'h3);
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 32'h0, 32'h0, 4'h0);

        // Both requesters continuously valid
        m0_req_valid = 1'b1; m0_addr = 32'h4; m0_wstrb = 4'h0;
        m1_req_valid = 1'b1; m1_addr = 32'h8; m1_wstrb = 4'h0;
        repeat (6) @(posedge tb_clk);
        #1;
        // Busy stall in RUN with both still valid
        bram_rst_busy = 1'b1;
        repeat (2) @(posedge tb_clk);
        #1 bram_rst_busy = 1'b0;
        repeat (4) @(posedge tb_clk);
        #1 m0_req_valid = 1'b0; m1_req_valid = 1'b0;

        // Random traffic with occasional busy pulses
        for (int c = 0; c < 400; c++) begin
            @(negedge tb_clk);
            a0 = m0_req_valid && m0_req_ready;
            a1 = m1_req_valid && m1_req_ready;
            @(posedge tb_clk); #1;
            if (!m0_req_valid || a0) begin
                m0_req_valid = ($urandom_range(0, 2) != 0);
                rand_req(m0_addr, m0_wdata, m0_wstrb);
            end
            if (!m1_req_valid || a1) begin
                m1_req_valid = ($urandom_range(0, 2) != 0);
                rand_req(m1_addr, m1_wdata, m1_wstrb);
            end
            bram_rst_busy = ($urandom_range(0, 15) == 0);
        end
        @(negedge tb_clk);
        @(posedge tb_clk); #1;
        m0_req_valid = 1'b0; m1_req_valid = 1'b0; bram_rst_busy = 1'b0;
        repeat (4) @(posedge tb_clk);
        #1;

        if (ADDR_CHECK) begin
            drive(1'b0, 32'h3, 32'h0, 4'h0);
            drive(1'b0, 32'h0004_0000, 32'h0, 4'h0);
            drive(1'b1, 32'h41, 32'h1234_5678, 4'hF);
            drive(1'b0, 32'h40, 32'h0, 4'h0);
        end

        // Reset with a read in flight: no response, init restarts
        drive(1'b0, 32'h8, 32'h0, 4'h0);
        rst_n = 1'b0;
        @(posedge tb_clk); #1;
        rst_n = 1'b1;
        repeat (RST_CYCLES + 4) @(posedge tb_clk);
        #1;
        drive(1'b1, 32'h4, 32'h0, 4'h0);

        repeat (6) @(posedge tb_clk);
        #1;
        chk("drain_m0", 32'(q0.size()), 32'd0);
        chk("drain_m1", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    // Bound on total run time
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
